// File: rtl/axi4_pmem_master.sv
// pmem-style request port to AXI4 INCR burst master, one transaction in flight.
// Writes stream beats from the requester; reads return one ack per R beat.
module axi4_pmem_master #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  inport_wr_i,
  input  logic        inport_rd_i,
  input  logic [7:0]  inport_len_i,
  input  logic [31:0] inport_addr_i,
  input  logic [31:0] inport_write_data_i,
  output logic        inport_accept_o,
  output logic        inport_ack_o,
  output logic        inport_error_o,
  output logic [31:0] inport_read_data_o,
  output logic        axi_awvalid_o,
  output logic [31:0] axi_awaddr_o,
  output logic [3:0]  axi_awid_o,
  output logic [7:0]  axi_awlen_o,
  output logic [1:0]  axi_awburst_o,
  output logic        axi_wvalid_o,
  output logic [31:0] axi_wdata_o,
  output logic [3:0]  axi_wstrb_o,
  output logic        axi_wlast_o,
  output logic        axi_bready_o,
  output logic        axi_arvalid_o,
  output logic [31:0] axi_araddr_o,
  output logic [3:0]  axi_arid_o,
  output logic [7:0]  axi_arlen_o,
  output logic [1:0]  axi_arburst_o,
  output logic        axi_rready_o,
  input  logic        axi_awready_i,
  input  logic        axi_wready_i,
  input  logic        axi_arready_i,
  input  logic        axi_bvalid_i,
  input  logic [1:0]  axi_bresp_i,
  input  logic [3:0]  axi_bid_i,
  input  logic        axi_rvalid_i,
  input  logic [31:0] axi_rdata_i,
  input  logic [1:0]  axi_rresp_i,
  input  logic [3:0]  axi_rid_i,
  input  logic        axi_rlast_i
);
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_t;

  state_t      state_q, state_d;
  logic [7:0]  beats_q;
  logic        aw_done_q, w_done_q, rdy_q;
  logic        wr_req, aw_hs, w_hs, ar_hs, b_hs, r_hs, wr_done, beat_acc;
  logic        unused_ids;

  assign unused_ids    = ^{axi_bid_i, axi_rid_i};
  assign axi_awid_o    = AXI_ID;
  assign axi_arid_o    = AXI_ID;
  assign axi_awburst_o = 2'b01;
  assign axi_arburst_o = 2'b01;

  assign wr_req   = |inport_wr_i;
  assign aw_hs    = axi_awvalid_o & axi_awready_i;
  assign w_hs     = axi_wvalid_o & axi_wready_i;
  assign ar_hs    = axi_arvalid_o & axi_arready_i;
  assign b_hs     = axi_bready_o & axi_bvalid_i;
  assign r_hs     = axi_rready_o & axi_rvalid_i;
  // AW and final W may complete in either order
  assign wr_done  = (w_done_q | (w_hs & axi_wlast_o)) & (aw_done_q | aw_hs);
  assign beat_acc = inport_accept_o & wr_req;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (beat_acc) state_d = WR_DATA;
               else if (inport_accept_o && inport_rd_i) state_d = RD_ADDR;
      WR_DATA: if (wr_done) state_d = WR_RESP;
      WR_RESP: if (b_hs) state_d = IDLE;
      RD_ADDR: if (ar_hs) state_d = RD_DATA;
      RD_DATA: if (r_hs && beats_q == 8'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rdy_q keeps accept low while reset is held and for the first edge after it
  always_comb begin
    inport_accept_o = 1'b0;
    unique case (state_q)
      IDLE:    inport_accept_o = rdy_q;
      WR_DATA: inport_accept_o = (beats_q != 8'd0) && (!axi_wvalid_o || axi_wready_i);
      default: inport_accept_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_q <= 1'b0; beats_q <= '0; aw_done_q <= 1'b0; w_done_q <= 1'b0;
      axi_awvalid_o <= 1'b0; axi_awaddr_o <= '0; axi_awlen_o <= '0;
      axi_wvalid_o <= 1'b0; axi_wdata_o <= '0; axi_wstrb_o <= '0; axi_wlast_o <= 1'b0;
      axi_bready_o <= 1'b0;
      axi_arvalid_o <= 1'b0; axi_araddr_o <= '0; axi_arlen_o <= '0;
      axi_rready_o <= 1'b0;
      inport_ack_o <= 1'b0; inport_error_o <= 1'b0; inport_read_data_o <= '0;
    end else begin
      rdy_q          <= 1'b1;
      inport_ack_o   <= 1'b0;
      inport_error_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (beat_acc) begin
            axi_awvalid_o <= 1'b1;
            axi_awaddr_o  <= {inport_addr_i[31:2], 2'b00};
            axi_awlen_o   <= inport_len_i;
            axi_wvalid_o  <= 1'b1;
            axi_wdata_o   <= inport_write_data_i;
            axi_wstrb_o   <= inport_wr_i;
            axi_wlast_o   <= (inport_len_i == 8'd0);
            beats_q       <= inport_len_i;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
          end else if (inport_accept_o && inport_rd_i) begin
            axi_arvalid_o <= 1'b1;
            axi_araddr_o  <= {inport_addr_i[31:2], 2'b00};
            axi_arlen_o   <= inport_len_i;
            beats_q       <= inport_len_i;
          end
        end
        WR_DATA: begin
          if (aw_hs) begin
            axi_awvalid_o <= 1'b0;
            aw_done_q     <= 1'b1;
          end
          if (w_hs && axi_wlast_o) w_done_q <= 1'b1;
          if (beat_acc) begin
            axi_wvalid_o <= 1'b1;
            axi_wdata_o  <= inport_write_data_i;
            axi_wstrb_o  <= inport_wr_i;
            axi_wlast_o  <= (beats_q == 8'd1);
            beats_q      <= beats_q - 8'd1;
          end else if (w_hs) begin
            axi_wvalid_o <= 1'b0;
          end
          if (wr_done) axi_bready_o <= 1'b1;
        end
        WR_RESP: begin
          if (b_hs) begin
            axi_bready_o   <= 1'b0;
            inport_ack_o   <= 1'b1;
            inport_error_o <= (axi_bresp_i != 2'b00);
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            axi_arvalid_o <= 1'b0;
            axi_rready_o  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            inport_ack_o       <= 1'b1;
            inport_read_data_o <= axi_rdata_i;
            // beat count is authoritative; a misplaced rlast is flagged, not obeyed
            inport_error_o     <= (axi_rresp_i != 2'b00) || (axi_rlast_i != (beats_q == 8'd0));
            if (beats_q == 8'd0) axi_rready_o <= 1'b0;
            else                 beats_q <= beats_q - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
